// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB, one 2-bit saturating counter per entry, trained by EXE.
// Prediction registered one cycle after lookup; lookups never stall EXE updates, IF_Stall freezes outputs.
module branch_predictor #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_Req,
  input  logic        IF_Stall,
  input  logic [31:0] IF_PC,
  output logic        Pred_Valid,
  output logic        Pred_Taken,
  output logic [31:0] Pred_Target,
  output logic        Pred_IsJump,
  input  logic        EXE_Upd_Valid,
  input  logic [31:0] EXE_Upd_PC,
  input  logic        EXE_Upd_IsBranch,
  input  logic        EXE_Upd_IsJump,
  input  logic        EXE_Upd_Taken,
  input  logic [31:0] EXE_Upd_Target,
  input  logic        EXE_Prediction_Failed,
  output logic [31:0] Stat_Lookups,
  output logic [31:0] Stat_Mispredicts
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_LO  = INDEX_W + 2;
  localparam int TAG_HI  = INDEX_W + TAG_W + 1;

  logic [ENTRIES-1:0] bt_valid;
  logic [ENTRIES-1:0] bt_isjump;
  logic [TAG_W-1:0]   bt_tag    [ENTRIES];
  logic [31:0]        bt_target [ENTRIES];
  logic [1:0]         bt_ctr    [ENTRIES];

  logic        u1_valid;
  logic        u1_isbranch;
  logic        u1_isjump;
  logic        u1_taken;
  logic [31:0] u1_pc;
  logic [31:0] u1_target;

  logic [INDEX_W-1:0] u1_idx;
  logic [TAG_W-1:0]   u1_tag;
  logic               unused_pc_bits;

  assign u1_idx         = u1_pc[INDEX_W+1:2];
  assign u1_tag         = u1_pc[TAG_HI:TAG_LO];
  assign unused_pc_bits = ^{u1_pc[1:0], u1_pc[31:TAG_HI+1]};

  // Next contents of the entry addressed by U1; written at the coming edge and
  // also forwarded to a lookup of the same index in this cycle.
  logic        cur_hit;
  logic        nx_valid;
  logic        nx_isjump;
  logic [TAG_W-1:0] nx_tag;
  logic [31:0] nx_target;
  logic [1:0]  nx_ctr;

  always_comb begin
    cur_hit   = bt_valid[u1_idx] && (bt_tag[u1_idx] == u1_tag);
    nx_valid  = bt_valid[u1_idx];
    nx_isjump = bt_isjump[u1_idx];
    nx_tag    = bt_tag[u1_idx];
    nx_target = bt_target[u1_idx];
    nx_ctr    = bt_ctr[u1_idx];
    if (u1_isjump) begin
      nx_valid  = 1'b1;
      nx_isjump = 1'b1;
      nx_tag    = u1_tag;
      nx_target = u1_target;
      nx_ctr    = 2'b11;
    end else if (u1_isbranch) begin
      if (cur_hit) begin
        if (u1_taken) begin
          nx_target = u1_target;
          if (bt_ctr[u1_idx] != 2'b11) nx_ctr = bt_ctr[u1_idx] + 2'd1;
        end else if (bt_ctr[u1_idx] != 2'b00) begin
          nx_ctr = bt_ctr[u1_idx] - 2'd1;
        end
      end else if (u1_taken) begin
        nx_valid  = 1'b1;
        nx_isjump = 1'b0;
        nx_tag    = u1_tag;
        nx_target = u1_target;
        nx_ctr    = 2'b10;
      end
    end else if (cur_hit) begin
      nx_valid = 1'b0;
    end
  end

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_bypass;
  logic               e_valid;
  logic               e_isjump;
  logic [TAG_W-1:0]   e_tag;
  logic [31:0]        e_target;
  logic [1:0]         e_ctr;
  logic               lk_hit;
  logic               lk_taken;
  logic [31:0]        pc_plus8;
  logic               lk_accept;

  assign lk_idx    = IF_PC[INDEX_W+1:2];
  assign lk_tag    = IF_PC[TAG_HI:TAG_LO];
  assign lk_bypass = u1_valid && (u1_idx == lk_idx);
  assign pc_plus8  = IF_PC + 32'd8;
  assign lk_accept = IF_Req && !IF_Stall;

  always_comb begin
    e_valid  = bt_valid[lk_idx];
    e_isjump = bt_isjump[lk_idx];
    e_tag    = bt_tag[lk_idx];
    e_target = bt_target[lk_idx];
    e_ctr    = bt_ctr[lk_idx];
    if (lk_bypass) begin
      e_valid  = nx_valid;
      e_isjump = nx_isjump;
      e_tag    = nx_tag;
      e_target = nx_target;
      e_ctr    = nx_ctr;
    end
  end

  assign lk_hit   = e_valid && (e_tag == lk_tag);
  assign lk_taken = lk_hit && (e_isjump || e_ctr[1]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Pred_Valid  <= 1'b0;
      Pred_Taken  <= 1'b0;
      Pred_Target <= 32'd0;
      Pred_IsJump <= 1'b0;
    end else if (!IF_Stall) begin
      if (IF_Req) begin
        Pred_Valid  <= lk_hit;
        Pred_Taken  <= lk_taken;
        Pred_Target <= lk_taken ? e_target : pc_plus8;
        Pred_IsJump <= lk_hit && e_isjump;
      end else begin
        Pred_Valid  <= 1'b0;
        Pred_Taken  <= 1'b0;
        Pred_Target <= 32'd0;
        Pred_IsJump <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      u1_valid    <= 1'b0;
      u1_isbranch <= 1'b0;
      u1_isjump   <= 1'b0;
      u1_taken    <= 1'b0;
      u1_pc       <= 32'd0;
      u1_target   <= 32'd0;
    end else begin
      u1_valid <= EXE_Upd_Valid;
      if (EXE_Upd_Valid) begin
        u1_isbranch <= EXE_Upd_IsBranch;
        u1_isjump   <= EXE_Upd_IsJump;
        u1_taken    <= EXE_Upd_Taken;
        u1_pc       <= EXE_Upd_PC;
        u1_target   <= EXE_Upd_Target;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bt_valid  <= '0;
      bt_isjump <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        bt_tag[i]    <= '0;
        bt_target[i] <= 32'd0;
        bt_ctr[i]    <= 2'b01;
      end
    end else if (u1_valid) begin
      bt_valid[u1_idx]  <= nx_valid;
      bt_isjump[u1_idx] <= nx_isjump;
      bt_tag[u1_idx]    <= nx_tag;
      bt_target[u1_idx] <= nx_target;
      bt_ctr[u1_idx]    <= nx_ctr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Stat_Lookups     <= 32'd0;
      Stat_Mispredicts <= 32'd0;
    end else begin
      if (lk_accept && (Stat_Lookups != 32'hFFFF_FFFF))
        Stat_Lookups <= Stat_Lookups + 32'd1;
      if (EXE_Upd_Valid && EXE_Prediction_Failed && (Stat_Mispredicts != 32'hFFFF_FFFF))
        Stat_Mispredicts <= Stat_Mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, saturation, bypass, alias, stall and reset.
`timescale 1ns/1ps
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        resetn;
  logic        IF_Req;
  logic        IF_Stall;
  logic [31:0] IF_PC;
  logic        Pred_Valid;
  logic        Pred_Taken;
  logic [31:0] Pred_Target;
  logic        Pred_IsJump;
  logic        EXE_Upd_Valid;
  logic [31:0] EXE_Upd_PC;
  logic        EXE_Upd_IsBranch;
  logic        EXE_Upd_IsJump;
  logic        EXE_Upd_Taken;
  logic [31:0] EXE_Upd_Target;
  logic        EXE_Prediction_Failed;
  logic [31:0] Stat_Lookups;
  logic [31:0] Stat_Mispredicts;

  int checks = 0;
  int errors = 0;
  int exp_lookups = 0;
  int exp_misp = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .resetn(resetn),
    .IF_Req(IF_Req), .IF_Stall(IF_Stall), .IF_PC(IF_PC),
    .Pred_Valid(Pred_Valid), .Pred_Taken(Pred_Taken),
    .Pred_Target(Pred_Target), .Pred_IsJump(Pred_IsJump),
    .EXE_Upd_Valid(EXE_Upd_Valid), .EXE_Upd_PC(EXE_Upd_PC),
    .EXE_Upd_IsBranch(EXE_Upd_IsBranch), .EXE_Upd_IsJump(EXE_Upd_IsJump),
    .EXE_Upd_Taken(EXE_Upd_Taken), .EXE_Upd_Target(EXE_Upd_Target),
    .EXE_Prediction_Failed(EXE_Prediction_Failed),
    .Stat_Lookups(Stat_Lookups), .Stat_Mispredicts(Stat_Mispredicts)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic v,
                        input logic t, input logic [31:0] tgt, input logic j);
    IF_Req = 1'b1;
    IF_PC  = pc;
    @(posedge clk);
    #1;
    IF_Req = 1'b0;
    exp_lookups++;
    expect_eq({tag, ".vld"}, {31'd0, Pred_Valid}, {31'd0, v});
    expect_eq({tag, ".tkn"}, {31'd0, Pred_Taken}, {31'd0, t});
    expect_eq({tag, ".tgt"}, Pred_Target, tgt);
    expect_eq({tag, ".jmp"}, {31'd0, Pred_IsJump}, {31'd0, j});
  endtask

  task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                     input logic tkn, input logic [31:0] tgt, input logic fail);
    EXE_Upd_Valid         = 1'b1;
    EXE_Upd_PC            = pc;
    EXE_Upd_IsBranch      = br;
    EXE_Upd_IsJump        = jmp;
    EXE_Upd_Taken         = tkn;
    EXE_Upd_Target        = tgt;
    EXE_Prediction_Failed = fail;
    @(posedge clk);
    #1;
    EXE_Upd_Valid         = 1'b0;
    EXE_Prediction_Failed = 1'b0;
    if (fail) exp_misp++;
  endtask

  initial begin
    resetn = 1'b0; IF_Req = 1'b0; IF_Stall = 1'b0; IF_PC = 32'd0;
    EXE_Upd_Valid = 1'b0; EXE_Upd_PC = 32'd0; EXE_Upd_IsBranch = 1'b0;
    EXE_Upd_IsJump = 1'b0; EXE_Upd_Taken = 1'b0; EXE_Upd_Target = 32'd0;
    EXE_Prediction_Failed = 1'b0;
    idle(3);
    expect_eq("rst.vld", {31'd0, Pred_Valid}, 32'd0);
    expect_eq("rst.tgt", Pred_Target, 32'd0);
    expect_eq("rst.lookups", Stat_Lookups, 32'd0);
    expect_eq("rst.misp", Stat_Mispredicts, 32'd0);
    @(negedge clk) resetn = 1'b1;
    idle(1);

    // 1: cold miss
    lookup("t1.miss", 32'h8000_0100, 1'b0, 1'b0, 32'h8000_0108, 1'b0);

    // 2: allocate, then train down with saturation at 00
    upd(32'h8000_0100, 1'b1, 1'b0, 1'b1, 32'h8000_0200, 1'b0); idle(1);
    lookup("t2.alloc", 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    upd(32'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1); idle(1);
    lookup("t2.ctr01", 32'h8000_0100, 1'b1, 1'b0, 32'h8000_0108, 1'b0);
    upd(32'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0); idle(1);
    upd(32'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0); idle(1);
    upd(32'h8000_0100, 1'b1, 1'b0, 1'b1, 32'h8000_0200, 1'b0); idle(1);
    lookup("t2.sat00", 32'h8000_0100, 1'b1, 1'b0, 32'h8000_0108, 1'b0);
    upd(32'h8000_0100, 1'b1, 1'b0, 1'b1, 32'h8000_0200, 1'b0); idle(1);
    lookup("t2.ctr10", 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0200, 1'b0);

    // 3: jump entry keeps isjump through not-taken branch training
    upd(32'h8000_0040, 1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0); idle(1);
    lookup("t3.jump", 32'h8000_0040, 1'b1, 1'b1, 32'h8000_1000, 1'b1);
    upd(32'h8000_0040, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1); idle(1);
    lookup("t3.ctr10", 32'h8000_0040, 1'b1, 1'b1, 32'h8000_1000, 1'b1);
    upd(32'h8000_0040, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0); idle(1);
    lookup("t3.ctr01", 32'h8000_0040, 1'b1, 1'b1, 32'h8000_1000, 1'b1);
    upd(32'h8000_0044, 1'b1, 1'b1, 1'b0, 32'h8000_4000, 1'b0); idle(1);
    lookup("t3.both", 32'h8000_0044, 1'b1, 1'b1, 32'h8000_4000, 1'b1);

    // 4: bypass from U1, then back-to-back updates to one index
    upd(32'h8000_0300, 1'b1, 1'b0, 1'b1, 32'h8000_3000, 1'b0);
    lookup("t4.bypass", 32'h8000_0300, 1'b1, 1'b1, 32'h8000_3000, 1'b0);
    upd(32'h8000_0080, 1'b1, 1'b0, 1'b1, 32'h8000_0800, 1'b0); idle(1);
    upd(32'h8000_0080, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0); idle(1);
    lookup("t4.ctr01", 32'h8000_0080, 1'b1, 1'b0, 32'h8000_0088, 1'b0);
    for (int i = 0; i < 4; i++) upd(32'h8000_0080, 1'b1, 1'b0, 1'b1, 32'h8000_0800, 1'b0);
    idle(1);
    lookup("t4.b2b", 32'h8000_0080, 1'b1, 1'b1, 32'h8000_0800, 1'b0);
    upd(32'h8000_0080, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0); idle(1);
    lookup("t4.ctr10", 32'h8000_0080, 1'b1, 1'b1, 32'h8000_0800, 1'b0);
    upd(32'h8000_0080, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0); idle(1);
    lookup("t4.ctr01b", 32'h8000_0080, 1'b1, 1'b0, 32'h8000_0088, 1'b0);

    // 5: alias invalidates; not-taken miss does not allocate
    upd(32'h8000_0100, 1'b1, 1'b0, 1'b1, 32'h8000_0200, 1'b0); idle(1);
    lookup("t5.alloc", 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    upd(32'h8000_0100, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0); idle(1);
    lookup("t5.alias", 32'h8000_0100, 1'b0, 1'b0, 32'h8000_0108, 1'b0);
    upd(32'h8000_0500, 1'b1, 1'b0, 1'b0, 32'h8000_5000, 1'b0); idle(1);
    lookup("t5.ntmiss", 32'h8000_0500, 1'b0, 1'b0, 32'h8000_0508, 1'b0);
    expect_eq("t5.lookups", Stat_Lookups, exp_lookups);
    expect_eq("t5.misp", Stat_Mispredicts, exp_misp);

    // 6: stall freezes outputs and does not count
    lookup("t6.pre", 32'h8000_0040, 1'b1, 1'b1, 32'h8000_1000, 1'b1);
    IF_Stall = 1'b1;
    IF_Req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IF_PC = 32'h8000_0100 + 32'(i * 4);
      idle(1);
      expect_eq("t6.stall.vld", {31'd0, Pred_Valid}, 32'd1);
      expect_eq("t6.stall.tgt", Pred_Target, 32'h8000_1000);
    end
    IF_Stall = 1'b0;
    IF_Req   = 1'b0;
    idle(1);
    expect_eq("t6.noreq.vld", {31'd0, Pred_Valid}, 32'd0);
    expect_eq("t6.noreq.tgt", Pred_Target, 32'd0);
    expect_eq("t6.lookups", Stat_Lookups, exp_lookups);

    // 6: reset while a mispredicted update sits in U1
    upd(32'h8000_0600, 1'b0, 1'b1, 1'b1, 32'h8000_6000, 1'b1);
    expect_eq("t6.misp", Stat_Mispredicts, exp_misp);
    resetn = 1'b0;
    #2;
    exp_lookups = 0;
    exp_misp    = 0;
    expect_eq("t6.rst.misp", Stat_Mispredicts, exp_misp);
    expect_eq("t6.rst.lookups", Stat_Lookups, exp_lookups);
    idle(2);
    @(negedge clk) resetn = 1'b1;
    idle(2);
    lookup("t6.nowrite", 32'h8000_0600, 1'b0, 1'b0, 32'h8000_0608, 1'b0);
    lookup("t6.cleared", 32'h8000_0040, 1'b0, 1'b0, 32'h8000_0048, 1'b0);
    expect_eq("t6.post.lookups", Stat_Lookups, exp_lookups);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
